// File: rtl/clock_div_monitor_if.sv
// Signal bundle between a divided-clock source and its health monitor.
// The master drives the clock under test and the error clear; the slave reports measurements.
interface clock_div_monitor_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ERR_W = 8
);
  logic             clkDivIn;
  logic             clrErr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] highCnt;
  logic             measValid;
  logic             periodErr;
  logic             dutyErr;
  logic             locked;
  logic             stuck;
  logic [ERR_W-1:0] errCnt;

  modport master (
    output clkDivIn, clrErr,
    input  period, highCnt, measValid, periodErr, dutyErr, locked, stuck, errCnt
  );

  modport slave (
    input  clkDivIn, clrErr,
    output period, highCnt, measValid, periodErr, dutyErr, locked, stuck, errCnt
  );
endinterface

// File: rtl/clock_div_monitor.sv
// Health monitor for a divided clock: measures period and high time in clkIn cycles,
// checks them against EXP_DIV, tracks lock, counts bad measurements and flags a stuck clock.
module clock_div_monitor #(
  parameter int unsigned EXP_DIV  = 5,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned ERR_W    = 8
) (
  input  logic               clkIn,
  input  logic               reset,
  clock_div_monitor_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACQ    = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int unsigned      MW      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0] H_MIN   = CNT_W'(EXP_DIV / 2);
  localparam logic [CNT_W-1:0] H_MAX   = CNT_W'((EXP_DIV + 1) / 2);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic             prev;
  logic             rise, fall, meas, perr, derr, bad, timeout;
  logic [CNT_W-1:0] cnt, h, hLast;
  logic [1:0]       state, state_nx;
  logic [MW-1:0]    matchCnt, match_nx;

  logic [CNT_W-1:0] period_q, high_q;
  logic             mv_q, perr_q, derr_q, locked_q, stuck_q;
  logic [ERR_W-1:0] err_q;

  always_comb begin
    rise    = bus.clkDivIn & ~prev;
    fall    = ~bus.clkDivIn & prev;
    perr    = (cnt != EXP_P);
    derr    = (hLast < H_MIN) | (hLast > H_MAX);
    bad     = perr | derr;
    meas    = rise & (state != IDLE);
    timeout = ~rise & (state != IDLE) & (cnt >= TO_CNT);
  end

  always_comb begin
    state_nx = state;
    match_nx = matchCnt;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = ACQ;
          match_nx = '0;
        end
      end
      ACQ: begin
        if (rise) begin
          if (bad) begin
            match_nx = '0;
          end else begin
            match_nx = matchCnt + 1'b1;
            if (match_nx == LOCK_M) state_nx = LOCKED;
          end
        end else if (timeout) begin
          state_nx = IDLE;
          match_nx = '0;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (bad) begin
            state_nx = ACQ;
            match_nx = '0;
          end
        end else if (timeout) begin
          state_nx = IDLE;
          match_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        match_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      prev     <= 1'b1;
      cnt      <= '0;
      h        <= '0;
      hLast    <= '0;
      state    <= IDLE;
      matchCnt <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      perr_q   <= 1'b0;
      derr_q   <= 1'b0;
      locked_q <= 1'b0;
      stuck_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      prev     <= bus.clkDivIn;
      state    <= state_nx;
      matchCnt <= match_nx;

      if (rise)                cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      // hLast captures the high run at the fall; highCnt publishes it at the next rise so
      // every measurement output moves together with measValid.
      if (rise) begin
        h <= CNT_W'(1);
      end else if (fall) begin
        hLast <= h;
        h     <= '0;
      end else if (bus.clkDivIn && (h != CNT_MAX)) begin
        h <= h + 1'b1;
      end

      mv_q <= meas;
      if (meas) begin
        period_q <= cnt;
        high_q   <= hLast;
        perr_q   <= perr;
        derr_q   <= derr;
      end
      locked_q <= (state_nx == LOCKED);

      if (bus.clrErr)                              err_q <= '0;
      else if (meas && bad && (err_q != ERR_MAX))  err_q <= err_q + 1'b1;

      if (bus.clrErr)   stuck_q <= 1'b0;
      else if (timeout) stuck_q <= 1'b1;
    end
  end

  assign bus.period    = period_q;
  assign bus.highCnt   = high_q;
  assign bus.measValid = mv_q;
  assign bus.periodErr = perr_q;
  assign bus.dutyErr   = derr_q;
  assign bus.locked    = locked_q;
  assign bus.stuck     = stuck_q;
  assign bus.errCnt    = err_q;
endmodule

// File: tb/tb_clock_div_monitor.sv
// Drives one shared divided-clock waveform into monitors expecting /4 and /5 and compares
// them against a per-period reference model built from the waveform's segment list.
module tb_clock_div_monitor;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned ERR_W    = 8;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned TIMEOUT  = 16;
  localparam int          ERR_MAX  = (1 << ERR_W) - 1;

  logic clkIn = 1'b0;
  logic reset = 1'b0;
  always #5 clkIn = ~clkIn;

  clock_div_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus4 ();
  clock_div_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus5 ();

  clock_div_monitor #(.EXP_DIV(4), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W))
    dut4 (.clkIn(clkIn), .reset(reset), .bus(bus4));
  clock_div_monitor #(.EXP_DIV(5), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W))
    dut5 (.clkIn(clkIn), .reset(reset), .bus(bus5));

  int checks = 0;
  int errors = 0;

  int exp_div[2] = '{4, 5};

  // Reference model state, one entry per monitor.
  int m_act[2], m_match[2], m_lk[2], m_st[2], m_ec[2];
  int m_per[2], m_hc[2], m_pe[2], m_de[2], m_mv[2];
  int prevN, prevH;

  logic             o_mv[2], o_pe[2], o_de[2], o_lk[2], o_st[2];
  logic [CNT_W-1:0] o_per[2], o_hc[2];
  logic [ERR_W-1:0] o_ec[2];

  always_comb begin
    o_mv[0]  = bus4.measValid; o_mv[1]  = bus5.measValid;
    o_pe[0]  = bus4.periodErr; o_pe[1]  = bus5.periodErr;
    o_de[0]  = bus4.dutyErr;   o_de[1]  = bus5.dutyErr;
    o_lk[0]  = bus4.locked;    o_lk[1]  = bus5.locked;
    o_st[0]  = bus4.stuck;     o_st[1]  = bus5.stuck;
    o_per[0] = bus4.period;    o_per[1] = bus5.period;
    o_hc[0]  = bus4.highCnt;   o_hc[1]  = bus5.highCnt;
    o_ec[0]  = bus4.errCnt;    o_ec[1]  = bus5.errCnt;
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s div%0d: observed %0d expected %0d", tag, exp_div[d], obs, expv);
    end
  endtask

  task automatic check_outputs(input string ph);
    for (int d = 0; d < 2; d++) begin
      chk({ph, ".measValid"}, d, 32'(o_mv[d]), m_mv[d]);
      chk({ph, ".period"},    d, 32'(o_per[d]), m_per[d]);
      chk({ph, ".highCnt"},   d, 32'(o_hc[d]), m_hc[d]);
      chk({ph, ".periodErr"}, d, 32'(o_pe[d]), m_pe[d]);
      chk({ph, ".dutyErr"},   d, 32'(o_de[d]), m_de[d]);
      chk({ph, ".locked"},    d, 32'(o_lk[d]), m_lk[d]);
      chk({ph, ".stuck"},     d, 32'(o_st[d]), m_st[d]);
      chk({ph, ".errCnt"},    d, 32'(o_ec[d]), m_ec[d]);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_match[d] = 0; m_lk[d] = 0; m_st[d] = 0; m_ec[d] = 0;
      m_per[d] = 0; m_hc[d] = 0; m_pe[d] = 0; m_de[d] = 0; m_mv[d] = 0;
    end
  endtask

  // A rise closes the previous segment: its length is the period, its high run the high time.
  task automatic model_rise(input int d, input bit clr);
    int e;
    e = exp_div[d];
    m_mv[d] = 0;
    if (m_act[d] == 0) begin
      m_act[d]   = 1;
      m_match[d] = 0;
    end else begin
      m_mv[d]  = 1;
      m_per[d] = prevN;
      m_hc[d]  = prevH;
      m_pe[d]  = (prevN != e) ? 1 : 0;
      m_de[d]  = (prevH < e / 2 || prevH > (e + 1) / 2) ? 1 : 0;
      if (m_pe[d] != 0 || m_de[d] != 0) begin
        m_match[d] = 0;
        m_lk[d]    = 0;
        if (m_ec[d] < ERR_MAX) m_ec[d]++;
      end else if (m_lk[d] == 0) begin
        m_match[d]++;
        if (m_match[d] == LOCK_CNT) m_lk[d] = 1;
      end
    end
    if (clr) begin
      m_ec[d] = 0;
      m_st[d] = 0;
    end
  endtask

  task automatic drive(input logic v, input logic c);
    bus4.clkDivIn = v; bus5.clkDivIn = v;
    bus4.clrErr   = c; bus5.clrErr   = c;
  endtask

  // One divided-clock period: n clkIn cycles, the first h of them high; optional clrErr on the rise.
  task automatic seg(input int n, input int h, input bit clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clkIn);
      if (i == 1) check_outputs("meas");
      if (i == 2) begin
        for (int d = 0; d < 2; d++) begin
          m_mv[d] = 0;
          chk("measValid_pulse", d, 32'(o_mv[d]), 0);
        end
      end
      if (i == TIMEOUT + 1) begin
        for (int d = 0; d < 2; d++) begin
          if (m_act[d] != 0) begin
            m_act[d] = 0; m_match[d] = 0; m_lk[d] = 0; m_st[d] = 1;
          end
        end
        check_outputs("timeout");
      end
      drive(i < h, (i == 0) && clr);
      if (i == 0) for (int d = 0; d < 2; d++) model_rise(d, clr);
    end
    prevN = n;
    prevH = h;
  endtask

  task automatic reset_mid();
    @(negedge clkIn);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clkIn);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    drive(1'b0, 1'b0);
    model_reset();
    prevN = 0;
    prevH = 0;
    repeat (3) @(negedge clkIn);
    check_outputs("reset");
    reset = 1'b1;

    repeat (8)  seg(4, 2, 1'b0);
    repeat (10) seg(5, int'($urandom_range(2, 3)), 1'b0);

    seg(30, 2, 1'b0);
    seg(5, 2, 1'b1);

    repeat (6) seg(5, 3, 1'b0);
    reset_mid();
    repeat (6) seg(5, int'($urandom_range(2, 3)), 1'b0);

    repeat (40) begin
      n = int'($urandom_range(2, 9));
      seg(n, int'($urandom_range(1, n - 1)), 1'b0);
    end

    repeat (262) seg(6, 3, 1'b0);
    seg(6, 3, 1'b1);
    repeat (2) seg(6, 3, 1'b0);
    @(negedge clkIn);
    check_outputs("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, observed time %0t required finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
